// File: rtl/request_demux_pkg.sv
// Shared definitions for the tagged request demultiplexer: counter width and
// helpers that split a request message and judge its tag.
package request_demux_pkg;

    localparam int unsigned ERR_CNT_W = 16;
    localparam int unsigned MAX_TAG_W = 64;
    localparam int unsigned MAX_MSG_W = 256;

    // Tag occupies the low tag_width bits of the message.
    function automatic logic [MAX_TAG_W-1:0] msg_tag(input logic [MAX_MSG_W-1:0] msg,
                                                     input int unsigned tag_width);
        logic [MAX_TAG_W-1:0] mask_s;
        mask_s = ~(64'hFFFF_FFFF_FFFF_FFFF << tag_width);
        return msg[MAX_TAG_W-1:0] & mask_s;
    endfunction

    function automatic logic [MAX_MSG_W-1:0] msg_payload(input logic [MAX_MSG_W-1:0] msg,
                                                         input int unsigned tag_width);
        return msg >> tag_width;
    endfunction

    function automatic logic tag_is_legal(input logic [MAX_TAG_W-1:0] tag,
                                          input int unsigned num_methods);
        return (tag != 64'h0) && (tag <= MAX_TAG_W'(num_methods));
    endfunction

endpackage

// File: rtl/request_input_demux_if.sv
// Enqueue and method-dispatch handshake bundle of the request demultiplexer.
interface request_input_demux_if #(
    parameter int unsigned NUM_METHODS   = 4,
    parameter int unsigned TAG_WIDTH     = 32,
    parameter int unsigned PAYLOAD_WIDTH = 64
);
    logic                               pipe_enq__ENA;
    logic [TAG_WIDTH+PAYLOAD_WIDTH-1:0] pipe_enq_v;
    logic                               pipe_enq__RDY;
    logic [NUM_METHODS-1:0]             meth__ENA;
    logic [PAYLOAD_WIDTH-1:0]           meth_v;
    logic [NUM_METHODS-1:0]             meth__RDY;

    modport master (
        output pipe_enq__ENA, pipe_enq_v, meth__RDY,
        input  pipe_enq__RDY, meth__ENA, meth_v
    );

    modport slave (
        input  pipe_enq__ENA, pipe_enq_v, meth__RDY,
        output pipe_enq__RDY, meth__ENA, meth_v
    );
endinterface

// File: rtl/request_fifo.sv
// Generic in-order synchronous FIFO; enqueue into a full FIFO or dequeue from
// an empty one is ignored.
module request_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] deq_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             enq_ok_s;
    logic             deq_ok_s;

    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == CNT_W'(0));
    assign deq_data = mem_r[rd_ptr_r];
    assign enq_ok_s = enq && !full;
    assign deq_ok_s = deq && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (enq_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({enq_ok_s, deq_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage write.
    always_ff @(posedge CLK) begin
        if (nRST && enq_ok_s) begin
            mem_r[wr_ptr_r] <= enq_data;
        end
    end
endmodule

// File: rtl/request_input_demux.sv
// Buffers tagged requests in order and dispatches each to the method named by
// its tag; illegal tags are dropped and counted so they cannot wedge the path.
module request_input_demux
    import request_demux_pkg::*;
#(
    parameter int unsigned NUM_METHODS   = 4,
    parameter int unsigned TAG_WIDTH     = 32,
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    request_input_demux_if.slave bus,
    input  logic                 err_clear,
    output logic [ERR_CNT_W-1:0] bad_tag_count,
    output logic                 bad_tag_seen,
    output logic [TAG_WIDTH-1:0] last_bad_tag
);
    localparam int unsigned IDX_W   = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
    localparam int unsigned ENTRY_W = IDX_W + PAYLOAD_WIDTH;

    logic [TAG_WIDTH-1:0]     tag_s;
    logic [PAYLOAD_WIDTH-1:0] payload_s;
    logic [IDX_W-1:0]         enq_idx_s;
    logic                     tag_legal_s;
    logic                     rdy_s;
    logic                     enq_fire_s;
    logic                     good_enq_s;
    logic                     bad_enq_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [ENTRY_W-1:0]       head_s;
    logic [IDX_W-1:0]         head_idx_s;
    logic [NUM_METHODS-1:0]   ena_s;
    logic                     deq_s;
    logic [ERR_CNT_W-1:0]     bad_cnt_r;
    logic                     bad_seen_r;
    logic [TAG_WIDTH-1:0]     last_bad_r;

    assign tag_s       = TAG_WIDTH'(msg_tag(MAX_MSG_W'(bus.pipe_enq_v), TAG_WIDTH));
    assign payload_s   = PAYLOAD_WIDTH'(msg_payload(MAX_MSG_W'(bus.pipe_enq_v), TAG_WIDTH));
    assign tag_legal_s = tag_is_legal(MAX_TAG_W'(tag_s), NUM_METHODS);
    assign enq_idx_s   = IDX_W'(tag_s - TAG_WIDTH'(1));

    // Ready depends only on occupancy and reset, never on meth__RDY.
    always_comb begin
        rdy_s = 1'b0;
        if (nRST && !fifo_full_s) begin
            rdy_s = 1'b1;
        end else begin
            rdy_s = 1'b0;
        end
    end

    assign enq_fire_s = bus.pipe_enq__ENA && rdy_s;
    assign good_enq_s = enq_fire_s && tag_legal_s;
    assign bad_enq_s  = enq_fire_s && !tag_legal_s;

    request_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .enq      (good_enq_s),
        .enq_data ({enq_idx_s, payload_s}),
        .deq      (deq_s),
        .deq_data (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    assign head_idx_s = head_s[ENTRY_W-1:PAYLOAD_WIDTH];

    // One-hot dispatch of the head entry to its method when that method is ready.
    always_comb begin
        ena_s = '0;
        for (int m = 0; m < int'(NUM_METHODS); m++) begin
            if (nRST && !fifo_empty_s && (head_idx_s == IDX_W'(m)) && bus.meth__RDY[m]) begin
                ena_s[m] = 1'b1;
            end else begin
                ena_s[m] = 1'b0;
            end
        end
    end

    assign deq_s             = |ena_s;
    assign bus.pipe_enq__RDY = rdy_s;
    assign bus.meth__ENA     = ena_s;
    assign bus.meth_v        = head_s[PAYLOAD_WIDTH-1:0];

    // Error bookkeeping: err_clear beats a concurrent drop on count and flag, but the tag still loads.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            bad_cnt_r  <= ERR_CNT_W'(0);
            bad_seen_r <= 1'b0;
            last_bad_r <= TAG_WIDTH'(0);
        end else begin
            if (err_clear) begin
                bad_cnt_r  <= ERR_CNT_W'(0);
                bad_seen_r <= 1'b0;
            end else if (bad_enq_s) begin
                if (bad_cnt_r != {ERR_CNT_W{1'b1}}) begin
                    bad_cnt_r <= bad_cnt_r + ERR_CNT_W'(1);
                end
                bad_seen_r <= 1'b1;
            end
            if (bad_enq_s) begin
                last_bad_r <= tag_s;
            end else if (err_clear) begin
                last_bad_r <= TAG_WIDTH'(0);
            end
        end
    end

    assign bad_tag_count = bad_cnt_r;
    assign bad_tag_seen  = bad_seen_r;
    assign last_bad_tag  = last_bad_r;
endmodule
